// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-channel, W-bit valid/ready stream multiplexer with one
// registered output stage. Arbitration is either round-robin (mode=0) from a
// rotating pointer, or a fixed channel chosen by sel (mode=1). Each output beat
// also carries the index of the channel it came from.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   in_data[N*W]      - channel i data in bits [i*W +: W]
//   in_valid[N]       - per-channel valid
//   in_ready[N]       - per-channel ready (combinational, at most one bit set)
//   mode              - 0: round-robin, 1: fixed channel sel
//   sel[SELW]         - channel used in mode 1; values >= N grant nothing
//   out_data[W]       - registered data
//   out_ch[SELW]      - registered source-channel index
//   out_valid         - registered valid
//   out_ready         - consumer ready
module rr_stream_mux #(
    parameter int N    = 8,
    parameter int W    = 8,
    parameter int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    output logic [W-1:0]    out_data,
    output logic [SELW-1:0] out_ch,
    output logic            out_valid,
    input  logic            out_ready
);

    logic [SELW-1:0] ptr_q, ptr_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic [SELW-1:0] out_ch_q, out_ch_d;
    logic            out_valid_q, out_valid_d;

    logic            load;
    logic            grant_found;
    logic [SELW-1:0] grant_idx;
    logic [W-1:0]    grant_data;
    logic            xfer;

    // The output register can take a beat when empty or being drained this cycle.
    assign load = !out_valid_q || out_ready;

    // Channel search. In round-robin mode the scan starts at ptr_q and wraps;
    // ptr_q is always < N, so a single subtraction brings the index back in range
    // for any N, power of two or not.
    // NOTE: every signal written in an always_comb gets a default at the top so
    // no path leaves it unassigned (which would infer a latch).
    always_comb begin : grant_search
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        if (mode) begin
            // Comparing against each legal index means sel >= N matches nothing.
            for (int i = 0; i < N; i++) begin
                if (sel == SELW'(i) && in_valid[i]) begin
                    grant_found = 1'b1;
                    grant_idx   = SELW'(i);
                end
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = int'(ptr_q) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (!grant_found && in_valid[idx]) begin
                    grant_found = 1'b1;
                    grant_idx   = SELW'(idx);
                end
            end
        end
    end

    always_comb begin : data_select
        grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SELW'(i)) begin
                grant_data = in_data[i*W +: W];
            end
        end
    end

    // rst_n gates the handshake so no producer sees ready while reset is held.
    assign xfer = rst_n && load && grant_found;

    always_comb begin : ready_decode
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = xfer && (grant_idx == SELW'(i));
        end
    end

    always_comb begin : next_state
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            // A load also covers the simultaneous drain: no bubble between beats.
            out_data_d  = grant_data;
            out_ch_d    = grant_idx;
            out_valid_d = 1'b1;
            // The pointer follows transfers in both modes so a return to
            // round-robin continues fairly after the last served channel.
            ptr_d       = (grant_idx == SELW'(N - 1)) ? '0 : grant_idx + SELW'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value; the datapath is reset too because its reset value of
    // zero is externally visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule
